// File: rtl/seg_capture_if.sv
// Bus bundle for seg_capture: the snooped anode/segment lines going in and
// the reconstructed per-digit display contents coming out.
interface seg_capture_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0]   an_i;
  logic [7:0]              seg_i;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic [NUM_DIGITS-1:0]   ltr_o;
  logic [NUM_DIGITS-1:0]   dp_o;
  logic [NUM_DIGITS-1:0]   valid_o;
  logic                    upd_o;
  logic [IDX_W-1:0]        upd_idx_o;
  logic                    err_o;

  // Side that drives the display bus and observes the capture results.
  modport master (
    output an_i, seg_i,
    input  digits_o, ltr_o, dp_o, valid_o, upd_o, upd_idx_o, err_o
  );

  // Capture block: listens to the bus and reports what it saw.
  modport slave (
    input  an_i, seg_i,
    output digits_o, ltr_o, dp_o, valid_o, upd_o, upd_idx_o, err_o
  );
endinterface

// File: rtl/seg_capture.sv
// Seven-segment bus snooper. Watches the time-multiplexed active-low
// anode/segment lines and rebuilds the code, letter flag and decimal point
// shown on each digit once a strobe/pattern pair has been stable long enough.
module seg_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  seg_capture_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMMIT,
    HELD
  } state_t;

  // Segment pattern a..g (active-low) -> {legal, ltr, code[3:0]}.
  // The letter I shares its pattern with 1 and is reported as 1.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'b0000001: res = {1'b1, 1'b0, 4'h0};
      7'b1001111: res = {1'b1, 1'b0, 4'h1};
      7'b0010010: res = {1'b1, 1'b0, 4'h2};
      7'b0000110: res = {1'b1, 1'b0, 4'h3};
      7'b1001100: res = {1'b1, 1'b0, 4'h4};
      7'b0100100: res = {1'b1, 1'b0, 4'h5};
      7'b1100000: res = {1'b1, 1'b0, 4'h6};
      7'b0001111: res = {1'b1, 1'b0, 4'h7};
      7'b0000000: res = {1'b1, 1'b0, 4'h8};
      7'b0001100: res = {1'b1, 1'b0, 4'h9};
      7'b1001000: res = {1'b1, 1'b1, 4'h5};
      7'b1111111: res = {1'b1, 1'b0, 4'hF};
      default:    res = {1'b0, 1'b0, 4'h0};
    endcase
    return res;
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   p_an;
  logic [7:0]              p_seg;

  logic                    an_ok;
  logic                    chg;
  logic [IDX_W-1:0]        k;
  logic [5:0]              dec;
  logic                    commit;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   ltr;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   valid;
  logic                    upd;
  logic [IDX_W-1:0]        upd_idx;
  logic                    err;

  // Register the bus once, and keep the previous sample for change detection.
  // Idle-high reset values make the bus look quiet right after reset, so a
  // held strobe must be recaptured and fully re-counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_an  <= '1;
      r_seg <= '1;
      p_an  <= '1;
      p_seg <= '1;
    end else begin
      r_an  <= bus.an_i;
      r_seg <= bus.seg_i;
      p_an  <= r_an;
      p_seg <= r_seg;
    end
  end

  assign an_ok  = $onehot(~r_an);
  assign chg    = (r_an != p_an) || (r_seg != p_seg);
  assign dec    = decode(r_seg[7:1]);
  assign commit = (state_nxt == COMMIT);

  // Locate the single active (low) anode; only meaningful when an_ok.
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an[i]) k = IDX_W'(i);
    end
  end

  // FSM state and stability counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. The commit is decided on the same edge the counter
  // would reach STABLE_CYCLES, so the registered pulse lands in the cycle
  // right after that edge; with STABLE_CYCLES = 1 the first stable sample
  // commits immediately.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (an_ok) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = (STABLE_CYCLES == 1) ? COMMIT : COUNT;
        end
      end
      COUNT: begin
        if (chg) begin
          if (an_ok) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = (STABLE_CYCLES == 1) ? COMMIT : COUNT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(STABLE_CYCLES)) state_nxt = COMMIT;
        end
      end
      COMMIT, HELD: begin
        if (chg) begin
          if (an_ok) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = (STABLE_CYCLES == 1) ? COMMIT : COUNT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = HELD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured display contents: written only on a commit. An illegal stable
  // pattern invalidates the digit but keeps its last good code/ltr/dp.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digits  <= '0;
      ltr     <= '0;
      dp      <= '0;
      valid   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      if (commit) begin
        if (dec[5]) begin
          digits[4*int'(k) +: 4] <= dec[3:0];
          ltr[k]                 <= dec[4];
          dp[k]                  <= ~r_seg[0];
          valid[k]               <= 1'b1;
          upd                    <= 1'b1;
          upd_idx                <= k;
        end else begin
          valid[k] <= 1'b0;
          err      <= 1'b1;
        end
      end
    end
  end

  assign bus.digits_o  = digits;
  assign bus.ltr_o     = ltr;
  assign bus.dp_o      = dp;
  assign bus.valid_o   = valid;
  assign bus.upd_o     = upd;
  assign bus.upd_idx_o = upd_idx;
  assign bus.err_o     = err;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with 8 digits and a 4-cycle stability window.
module tb_seg_capture;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   upd_cnt;
  int   err_cnt;
  int   both_cnt;
  int   c_upd;
  int   c_err;

  seg_capture_if #(.NUM_DIGITS(8)) bus ();

  seg_capture #(
    .NUM_DIGITS   (8),
    .STABLE_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the active edge (values from the prior cycle).
  always @(posedge clk) begin
    if (bus.upd_o === 1'b1) upd_cnt <= upd_cnt + 1;
    if (bus.err_o === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.upd_o === 1'b1 && bus.err_o === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg);
    bus.an_i  = an;
    bus.seg_i = seg;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digits"}, 64'(bus.digits_o), 64'h0);
    chk({tag, "_valid"}, 64'(bus.valid_o), 64'h0);
    chk({tag, "_ltr"}, 64'(bus.ltr_o), 64'h0);
    chk({tag, "_dp"}, 64'(bus.dp_o), 64'h0);
    chk({tag, "_upd"}, 64'(bus.upd_o), 64'h0);
    chk({tag, "_err"}, 64'(bus.err_o), 64'h0);
    chk({tag, "_idx"}, 64'(bus.upd_idx_o), 64'h0);
  endtask

  // Segment codes for digits 0..9 with the decimal point off.
  logic [7:0] pat [10];

  initial begin
    total    = 0;
    bad      = 0;
    upd_cnt  = 0;
    err_cnt  = 0;
    both_cnt = 0;
    pat[0] = 8'h03; pat[1] = 8'h9F; pat[2] = 8'h25; pat[3] = 8'h0D; pat[4] = 8'h99;
    pat[5] = 8'h49; pat[6] = 8'hC1; pat[7] = 8'h1F; pat[8] = 8'h01; pat[9] = 8'h19;

    // Reset state
    rst = 1'b1;
    drive(8'hFF, 8'hFF);
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(3);

    // Test 1: digit 3 on anode 2, exact latency
    c_upd = upd_cnt;
    c_err = err_cnt;
    drive(8'hFB, 8'h0D);
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i < 5) chk("t1_upd_early", 64'(bus.upd_o), 64'h0);
      if (i == 5) begin
        chk("t1_upd_pulse", 64'(bus.upd_o), 64'h1);
        chk("t1_idx", 64'(bus.upd_idx_o), 64'h2);
      end
      if (i == 6) chk("t1_upd_end", 64'(bus.upd_o), 64'h0);
    end
    chk("t1_code", 64'(bus.digits_o[11:8]), 64'h3);
    chk("t1_valid", 64'(bus.valid_o[2]), 64'h1);
    chk("t1_ltr", 64'(bus.ltr_o[2]), 64'h0);
    chk("t1_dp", 64'(bus.dp_o[2]), 64'h0);
    chk("t1_npulse", 64'(upd_cnt - c_upd), 64'h1);
    chk("t1_nerr", 64'(err_cnt - c_err), 64'h0);

    // Test 2: letter H then 1 with dp on anode 0
    c_upd = upd_cnt;
    drive(8'hFE, 8'h91);
    cyc(8);
    chk("t2_h_code", 64'(bus.digits_o[3:0]), 64'h5);
    chk("t2_h_ltr", 64'(bus.ltr_o[0]), 64'h1);
    chk("t2_h_dp", 64'(bus.dp_o[0]), 64'h0);
    drive(8'hFE, 8'h9E);
    cyc(8);
    chk("t2_1_code", 64'(bus.digits_o[3:0]), 64'h1);
    chk("t2_1_ltr", 64'(bus.ltr_o[0]), 64'h0);
    chk("t2_1_dp", 64'(bus.dp_o[0]), 64'h1);
    chk("t2_npulse", 64'(upd_cnt - c_upd), 64'h2);
    chk("t2_keep_d2", 64'(bus.digits_o[11:8]), 64'h3);

    // Test 3: glitching segments on anode 4
    c_upd = upd_cnt;
    c_err = err_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(8'hEF, pat[i]);
      cyc(3);
    end
    chk("t3_glitch_upd", 64'(upd_cnt - c_upd), 64'h0);
    chk("t3_glitch_err", 64'(err_cnt - c_err), 64'h0);
    chk("t3_glitch_code", 64'(bus.digits_o[19:16]), 64'h0);
    chk("t3_glitch_valid", 64'(bus.valid_o[4]), 64'h0);
    drive(8'hEF, pat[7]);
    cyc(8);
    chk("t3_final_upd", 64'(upd_cnt - c_upd), 64'h1);
    chk("t3_final_code", 64'(bus.digits_o[19:16]), 64'h7);
    chk("t3_final_valid", 64'(bus.valid_o[4]), 64'h1);

    // Test 4: legal then illegal pattern on anode 1
    drive(8'hFD, pat[4]);
    cyc(8);
    chk("t4_legal_code", 64'(bus.digits_o[7:4]), 64'h4);
    chk("t4_legal_valid", 64'(bus.valid_o[1]), 64'h1);
    c_upd = upd_cnt;
    c_err = err_cnt;
    drive(8'hFD, 8'h55);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("t4_no_upd", 64'(bus.upd_o), 64'h0);
      if (i == 5) chk("t4_err_pulse", 64'(bus.err_o), 64'h1);
      if (i == 6) chk("t4_err_end", 64'(bus.err_o), 64'h0);
    end
    chk("t4_nerr", 64'(err_cnt - c_err), 64'h1);
    chk("t4_nupd", 64'(upd_cnt - c_upd), 64'h0);
    chk("t4_valid", 64'(bus.valid_o[1]), 64'h0);
    chk("t4_keep_code", 64'(bus.digits_o[7:4]), 64'h4);

    // Test 5: two anodes low, then none low
    c_upd = upd_cnt;
    c_err = err_cnt;
    drive(8'hF3, pat[0]);
    cyc(20);
    drive(8'hFF, pat[0]);
    cyc(20);
    chk("t5_nupd", 64'(upd_cnt - c_upd), 64'h0);
    chk("t5_nerr", 64'(err_cnt - c_err), 64'h0);
    chk("t5_digits", 64'(bus.digits_o), 64'h0007_0341);
    chk("t5_valid", 64'(bus.valid_o), 64'h15);
    chk("t5_ltr", 64'(bus.ltr_o), 64'h00);
    chk("t5_dp", 64'(bus.dp_o), 64'h01);

    // Test 6: reset in the middle of a count on anode 3
    drive(8'hF7, pat[2]);
    cyc(3);
    c_upd = upd_cnt;
    rst = 1'b1;
    cyc(1);
    chk_all_zero("t6_in_reset");
    cyc(1);
    chk("t6_reset_digits", 64'(bus.digits_o), 64'h0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i < 5) chk("t6_upd_early", 64'(bus.upd_o), 64'h0);
      if (i == 5) begin
        chk("t6_upd_pulse", 64'(bus.upd_o), 64'h1);
        chk("t6_idx", 64'(bus.upd_idx_o), 64'h3);
      end
    end
    chk("t6_npulse", 64'(upd_cnt - c_upd), 64'h1);
    chk("t6_digits", 64'(bus.digits_o), 64'h0000_2000);
    chk("t6_valid", 64'(bus.valid_o), 64'h08);

    // Test 7: round-robin scan of all digits with values 0..7
    c_upd = upd_cnt;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), pat[d]);
      for (int i = 1; i <= 6; i++) begin
        cyc(1);
        if (i == 5) begin
          chk("t7_upd", 64'(bus.upd_o), 64'h1);
          chk("t7_idx", 64'(bus.upd_idx_o), 64'(d));
        end
      end
    end
    drive(8'hFF, 8'hFF);
    cyc(3);
    chk("t7_npulse", 64'(upd_cnt - c_upd), 64'h8);
    chk("t7_digits", 64'(bus.digits_o), 64'h7654_3210);
    chk("t7_valid", 64'(bus.valid_o), 64'hFF);
    chk("t7_ltr", 64'(bus.ltr_o), 64'h00);
    chk("t7_dp", 64'(bus.dp_o), 64'h00);

    chk("never_upd_and_err", 64'(both_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the seven-segment digit decoder.
- Snoops a time-multiplexed, active-low anode/segment bus (the same bus the display driver scans) and reconstructs the value shown on each digit: 4-bit code, letter flag and decimal point.
- Feeds self-check logic and the loopback test harness, which compare the commanded display contents against what actually reaches the pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (anode lines); range 1..16.
STABLE_CYCLES, 4, consecutive clocks an anode/segment pair must hold before it is committed; minimum 1.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  asynchronous active-high reset.
an_i  input  NUM_DIGITS  anode strobes, active-low; a valid strobe has exactly one bit low.
seg_i  input  8  segments, active-low; bit7..bit1 = a..g, bit0 = dp.
digits_o  output  4*NUM_DIGITS  captured codes; digit n occupies bits [4n+3:4n].
ltr_o  output  NUM_DIGITS  1 = digit n decoded as a letter.
dp_o  output  NUM_DIGITS  1 = decimal point lit on digit n.
valid_o  output  NUM_DIGITS  1 = digit n holds a legal, committed pattern.
upd_o  output  1  one-cycle pulse on each commit.
upd_idx_o  output  max(1,$clog2(NUM_DIGITS))  index of the digit committed; meaningful while upd_o = 1, holds its last value otherwise.
err_o  output  1  one-cycle pulse when a stable pattern is illegal.

Behaviour:
- Reset: every output goes to 0 (digits_o all zero; valid_o, ltr_o, dp_o, upd_o, err_o, upd_idx_o all 0), FSM goes to IDLE, counter clears. Reset mid-count aborts the pending commit, with no pulse.
- Input stage: an_i and seg_i are registered once into r_an/r_seg. All comparisons use the registered values.
- Pattern table (seg[7:1] -> code, ltr):
  - 0000001 -> 0,0
  - 1001111 -> 1,0
  - 0010010 -> 2,0
  - 0000110 -> 3,0
  - 1001100 -> 4,0
  - 0100100 -> 5,0
  - 1100000 -> 6,0
  - 0001111 -> 7,0
  - 0000000 -> 8,0
  - 0001100 -> 9,0
  - 1001000 -> 5,1 (H)
  - 1111111 -> F,0 (blank; legal)
  - Any other pattern is illegal.
  - Letter I shares 1001111 with digit 1 and always decodes as 1,0.
  - dp decodes independently: dp = ~seg[0].
- FSM states:
  - IDLE: r_an is not one-hot-low (all high or more than one low). Enter COUNT, with counter = 1, on the first cycle r_an is one-hot-low.
  - COUNT: if {r_an, r_seg} differs from the previous cycle, restart the counter at 1, or go to IDLE if the new r_an is invalid. When the counter reaches STABLE_CYCLES, go to COMMIT.
  - COMMIT (one cycle), for digit k (the low bit of r_an):
    - Legal pattern: write code, ltr and dp for digit k; set valid_o[k]; pulse upd_o; drive upd_idx_o = k.
    - Illegal pattern: pulse err_o; clear valid_o[k]; leave code, ltr and dp for digit k unchanged.
    - Then go to HELD.
  - HELD: no further commits while {r_an, r_seg} is unchanged. On a change, go to COUNT (counter = 1) if r_an is valid, else IDLE.
- Latency: with inputs applied before clock edge e and held, upd_o/err_o is high in the cycle after edge e+STABLE_CYCLES. For STABLE_CYCLES = 1 this is the cycle after edge e+1.
- upd_o and err_o are never high together. A held pattern produces exactly one pulse.
- Untouched digits keep their contents and valid bits indefinitely.
- Registers update only on commit. All outputs are registered.

Test Plan:
1. STABLE_CYCLES = 4. Hold an_i = 8'b11111011, seg_i = 8'b00001101 for 10 cycles -> one upd_o pulse in the cycle after edge e+4; upd_idx_o = 2; digits_o[11:8] = 3; valid_o[2] = 1; ltr_o[2] = 0; dp_o[2] = 0.
2. an_i = 8'b11111110, seg_i = 8'b10010001 held -> digits_o[3:0] = 5, ltr_o[0] = 1. Then seg_i = 8'b10011110 held -> digits_o[3:0] = 1, ltr_o[0] = 0, dp_o[0] = 1, second upd_o pulse.
3. Glitch: seg_i changes every 3 cycles on anode 4 for 30 cycles -> no upd_o, no err_o, digit 4 unchanged. Final value then held 4 cycles -> exactly one commit.
4. Illegal pattern seg_i = 8'b01010101 held on anode 1, after a prior legal commit there -> one err_o pulse, valid_o[1] = 0, digits_o[7:4] keeps its prior value, upd_o stays 0.
5. an_i = 8'b11110011 (two low) or 8'hFF held 20 cycles -> IDLE; no pulses; all outputs unchanged.
6. Assert rst_i at count 2 of a pending commit, release, keep inputs held -> all outputs 0 during reset; after release a fresh full STABLE_CYCLES count elapses before the commit.
7. Scan all 8 digits round-robin, 6 cycles each, values 0..7 -> 8 commits with upd_idx_o 0..7 in order; digits_o = 32'h76543210; valid_o = 8'hFF.
